// File: rtl/stack_row_sequencer_pkg.sv
// Shared definitions for the stacking-game row sequencer: state encoding,
// board geometry and legal parameter ranges.
package stack_row_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_MOVE  = 3'd2,
        S_PLACE = 3'd3,
        S_NEXT  = 3'd4,
        S_WIN   = 3'd5,
        S_LOSE  = 3'd6
    } seq_state_t;

    localparam int GRID_DIM        = 8;
    localparam int BASE_PERIOD_MIN = 8;
    localparam int BASE_PERIOD_MAX = 15;
    localparam int INIT_WIDTH_MIN  = 1;

    // Right-aligned run of w ones: the starting segment.
    function automatic logic [7:0] low_ones(input int w);
        return 8'((1 << w) - 1);
    endfunction

endpackage

// File: rtl/stack_row_sequencer_ticker.sv
// Speed tick generator: free-running prescaler feeding a threshold counter.
// restart zeroes both so the first tick lands one full interval later.
module stack_speed_ticker #(
    parameter int TICK_DIV_W = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       restart,
    input  logic [3:0] period,
    output logic       tick
);
    logic [TICK_DIV_W-1:0] pre_cnt;
    logic [3:0]            tick_cnt;
    logic                  pre_pulse;

    // Pulse on the cycle the prescaler wraps back to zero.
    assign pre_pulse = &pre_cnt;
    assign tick      = pre_pulse && (tick_cnt == period) && !restart;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_cnt  <= '0;
            tick_cnt <= '0;
        end else if (restart) begin
            pre_cnt  <= '0;
            tick_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + TICK_DIV_W'(1);
            if (pre_pulse)
                tick_cnt <= (tick_cnt == period) ? 4'd0 : tick_cnt + 4'd1;
        end
    end

endmodule

// File: rtl/stack_row_sequencer.sv
// Stacking-game controller: slides the segment, captures the press, computes
// overlap with the row below and drives the block-array write port.
module stack_row_sequencer
    import stack_row_sequencer_pkg::*;
#(
    parameter int BASE_PERIOD = 12,
    parameter int TICK_DIV_W  = 20,
    parameter int INIT_WIDTH  = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn,
    output logic [7:0] val,
    output logic [2:0] row_index,
    output logic       write_strobe,
    output logic       clr_array,
    output logic [2:0] state,
    output logic [3:0] period,
    output logic       win,
    output logic       lose
);
    if (BASE_PERIOD < BASE_PERIOD_MIN || BASE_PERIOD > BASE_PERIOD_MAX ||
        INIT_WIDTH < INIT_WIDTH_MIN || INIT_WIDTH > GRID_DIM) begin : g_bad_param
        $error("stack_row_sequencer: parameter out of range");
    end

    localparam logic [7:0] INIT_VAL = low_ones(INIT_WIDTH);
    localparam logic [2:0] TOP_ROW  = 3'(GRID_DIM - 1);

    seq_state_t st, nxt;
    logic       dir_left, dir_left_d;
    logic [7:0] below, below_d, val_d;
    logic [2:0] row_d;
    logic       strobe_d, clr_d, win_d, lose_d;
    logic       tick;

    assign state  = st;
    assign period = 4'(BASE_PERIOD) - {1'b0, row_index};

    stack_speed_ticker #(.TICK_DIV_W(TICK_DIV_W)) u_ticker (
        .clk     (clk),
        .reset   (reset),
        .restart (st != S_MOVE),
        .period  (period),
        .tick    (tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) st <= S_IDLE;
        else        st <= nxt;
    end

    always_comb begin
        nxt = st;
        case (st)
            S_IDLE:  if (btn) nxt = S_CLEAR;
            S_CLEAR: nxt = S_MOVE;
            S_MOVE:  if (btn) nxt = S_PLACE;
            // val already holds the placed pattern during PLACE
            S_PLACE: begin
                if (val == 8'h00)            nxt = S_LOSE;
                else if (row_index == TOP_ROW) nxt = S_WIN;
                else                          nxt = S_NEXT;
            end
            S_NEXT:  nxt = S_MOVE;
            S_WIN,
            S_LOSE:  if (btn) nxt = S_CLEAR;
            default: nxt = S_IDLE;
        endcase
    end

    // Next values of the registered outputs, keyed on the transition taken.
    always_comb begin
        val_d      = val;
        row_d      = row_index;
        below_d    = below;
        dir_left_d = dir_left;
        strobe_d   = 1'b0;
        clr_d      = 1'b0;
        win_d      = win;
        lose_d     = lose;
        if (nxt == S_CLEAR && st != S_CLEAR) begin
            clr_d      = 1'b1;
            val_d      = INIT_VAL;
            row_d      = 3'd0;
            below_d    = 8'hFF;
            dir_left_d = 1'b1;
            win_d      = 1'b0;
            lose_d     = 1'b0;
        end else begin
            case (st)
                S_CLEAR, S_NEXT: strobe_d = 1'b1;
                S_MOVE: begin
                    if (nxt == S_PLACE) begin
                        val_d    = val & below;
                        strobe_d = 1'b1;
                    end else if (tick) begin
                        strobe_d = 1'b1;
                        // Bounce reverses and moves on the same tick.
                        if (val != 8'hFF) begin
                            if (dir_left) begin
                                if (val[7]) begin
                                    dir_left_d = 1'b0;
                                    val_d      = val >> 1;
                                end else begin
                                    val_d = val << 1;
                                end
                            end else begin
                                if (val[0]) begin
                                    dir_left_d = 1'b1;
                                    val_d      = val << 1;
                                end else begin
                                    val_d = val >> 1;
                                end
                            end
                        end
                    end
                end
                S_PLACE: begin
                    if (nxt == S_NEXT) begin
                        below_d = val;
                        row_d   = row_index + 3'd1;
                    end else if (nxt == S_WIN) begin
                        win_d = 1'b1;
                    end else begin
                        lose_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            val          <= 8'h00;
            row_index    <= 3'd0;
            below        <= 8'hFF;
            dir_left     <= 1'b1;
            write_strobe <= 1'b0;
            clr_array    <= 1'b0;
            win          <= 1'b0;
            lose         <= 1'b0;
        end else begin
            val          <= val_d;
            row_index    <= row_d;
            below        <= below_d;
            dir_left     <= dir_left_d;
            write_strobe <= strobe_d;
            clr_array    <= clr_d;
            win          <= win_d;
            lose         <= lose_d;
        end
    end

endmodule

// File: tb/tb_stack_row_sequencer.sv
// Directed bench for stack_row_sequencer with TICK_DIV_W=2 (row-0 tick every 52 clocks).
module tb_stack_row_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn = 1'b0;
    logic [7:0] val;
    logic [2:0] row_index;
    logic       write_strobe, clr_array, win, lose;
    logic [2:0] state;
    logic [3:0] period;

    int checks = 0;
    int errors = 0;

    stack_row_sequencer #(.BASE_PERIOD(12), .TICK_DIV_W(2), .INIT_WIDTH(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .btn          (btn),
        .val          (val),
        .row_index    (row_index),
        .write_strobe (write_strobe),
        .clr_array    (clr_array),
        .state        (state),
        .period       (period),
        .win          (win),
        .lose         (lose)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       btn;
        int         adv;
        logic [2:0] st;
        logic [7:0] val;
        logic [2:0] row;
        logic       stb, clr, win, lose;
        logic [3:0] per;
    } vec_t;

    vec_t vecs[24];

    function automatic vec_t mk(input logic b, input int a, input logic [2:0] s,
                                input logic [7:0] v, input logic [2:0] r, input logic stb,
                                input logic c, input logic w, input logic l, input logic [3:0] p);
        vec_t t;
        t.btn = b; t.adv = a; t.st = s; t.val = v; t.row = r;
        t.stb = stb; t.clr = c; t.win = w; t.lose = l; t.per = p;
        return t;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [2:0] s, input logic [7:0] v,
                       input logic [2:0] r, input logic stb, input logic c,
                       input logic w, input logic l, input logic [3:0] p);
        logic [21:0] act, exp;
        act = {state, val, row_index, write_strobe, clr_array, win, lose, period};
        exp = {s, v, r, stb, c, w, l, p};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got st=%0d val=%h row=%0d stb=%b clr=%b win=%b lose=%b per=%0d, want st=%0d val=%h row=%0d stb=%b clr=%b win=%b lose=%b per=%0d",
                     name, state, val, row_index, write_strobe, clr_array, win, lose, period,
                     s, v, r, stb, c, w, l, p);
        end
    endtask

    initial begin
        // Start, bounce, two overlapping placements, miss, restart.
        vecs[0]  = mk(1, 0,  3'd1, 8'h07, 3'd0, 0, 1, 0, 0, 4'd12);
        vecs[1]  = mk(0, 0,  3'd2, 8'h07, 3'd0, 1, 0, 0, 0, 4'd12);
        vecs[2]  = mk(0, 50, 3'd2, 8'h07, 3'd0, 0, 0, 0, 0, 4'd12);
        vecs[3]  = mk(0, 0,  3'd2, 8'h0E, 3'd0, 1, 0, 0, 0, 4'd12);
        vecs[4]  = mk(0, 51, 3'd2, 8'h1C, 3'd0, 1, 0, 0, 0, 4'd12);
        vecs[5]  = mk(0, 51, 3'd2, 8'h38, 3'd0, 1, 0, 0, 0, 4'd12);
        vecs[6]  = mk(0, 51, 3'd2, 8'h70, 3'd0, 1, 0, 0, 0, 4'd12);
        vecs[7]  = mk(0, 51, 3'd2, 8'hE0, 3'd0, 1, 0, 0, 0, 4'd12);
        vecs[8]  = mk(0, 51, 3'd2, 8'h70, 3'd0, 1, 0, 0, 0, 4'd12);
        vecs[9]  = mk(0, 51, 3'd2, 8'h38, 3'd0, 1, 0, 0, 0, 4'd12);
        vecs[10] = mk(1, 0,  3'd3, 8'h38, 3'd0, 1, 0, 0, 0, 4'd12);
        vecs[11] = mk(0, 0,  3'd4, 8'h38, 3'd1, 0, 0, 0, 0, 4'd11);
        vecs[12] = mk(0, 0,  3'd2, 8'h38, 3'd1, 1, 0, 0, 0, 4'd11);
        vecs[13] = mk(0, 46, 3'd2, 8'h38, 3'd1, 0, 0, 0, 0, 4'd11);
        vecs[14] = mk(0, 0,  3'd2, 8'h1C, 3'd1, 1, 0, 0, 0, 4'd11);
        vecs[15] = mk(1, 0,  3'd3, 8'h18, 3'd1, 1, 0, 0, 0, 4'd11);
        vecs[16] = mk(0, 0,  3'd4, 8'h18, 3'd2, 0, 0, 0, 0, 4'd10);
        vecs[17] = mk(0, 0,  3'd2, 8'h18, 3'd2, 1, 0, 0, 0, 4'd10);
        vecs[18] = mk(0, 87, 3'd2, 8'h06, 3'd2, 1, 0, 0, 0, 4'd10);
        vecs[19] = mk(1, 0,  3'd3, 8'h00, 3'd2, 1, 0, 0, 0, 4'd10);
        vecs[20] = mk(0, 0,  3'd6, 8'h00, 3'd2, 0, 0, 0, 1, 4'd10);
        vecs[21] = mk(0, 5,  3'd6, 8'h00, 3'd2, 0, 0, 0, 1, 4'd10);
        vecs[22] = mk(1, 0,  3'd1, 8'h07, 3'd0, 0, 1, 0, 0, 4'd12);
        vecs[23] = mk(0, 0,  3'd2, 8'h07, 3'd0, 1, 0, 0, 0, 4'd12);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_hold", 3'd0, 8'h00, 3'd0, 0, 0, 0, 0, 4'd12);
        @(negedge clk);
        reset = 1'b1;
        step();
        chk("idle_after_reset", 3'd0, 8'h00, 3'd0, 0, 0, 0, 0, 4'd12);

        for (int i = 0; i < 24; i++) begin
            btn = vecs[i].btn;
            step();
            btn = 1'b0;
            repeat (vecs[i].adv) step();
            chk($sformatf("vec%0d", i), vecs[i].st, vecs[i].val, vecs[i].row,
                vecs[i].stb, vecs[i].clr, vecs[i].win, vecs[i].lose, vecs[i].per);
        end

        // Eight aligned presses at the start of each row; btn held into PLACE on row 0.
        for (int r = 0; r < 8; r++) begin
            btn = 1'b1;
            step();
            if (r != 0) btn = 1'b0;
            chk($sformatf("win_place%0d", r), 3'd3, 8'h07, 3'(r), 1, 0, 0, 0, 4'(12 - r));
            step();
            btn = 1'b0;
            if (r < 7) begin
                chk($sformatf("win_next%0d", r), 3'd4, 8'h07, 3'(r + 1), 0, 0, 0, 0, 4'(11 - r));
                step();
                chk($sformatf("win_move%0d", r), 3'd2, 8'h07, 3'(r + 1), 1, 0, 0, 0, 4'(11 - r));
            end else begin
                chk("win_flag", 3'd5, 8'h07, 3'd7, 0, 0, 1, 0, 4'd5);
            end
        end
        step();
        chk("win_hold", 3'd5, 8'h07, 3'd7, 0, 0, 1, 0, 4'd5);
        btn = 1'b1;
        step();
        btn = 1'b0;
        chk("win_restart_clr", 3'd1, 8'h07, 3'd0, 0, 1, 0, 0, 4'd12);
        step();
        chk("win_restart_move", 3'd2, 8'h07, 3'd0, 1, 0, 0, 0, 4'd12);

        // Press lands on the tick cycle (MOVE cycle 51): no shift.
        repeat (51) step();
        btn = 1'b1;
        step();
        btn = 1'b0;
        chk("collide_place", 3'd3, 8'h07, 3'd0, 1, 0, 0, 0, 4'd12);
        step();
        chk("collide_next", 3'd4, 8'h07, 3'd1, 0, 0, 0, 0, 4'd11);
        step();
        chk("row1_entry", 3'd2, 8'h07, 3'd1, 1, 0, 0, 0, 4'd11);
        repeat (47) step();
        chk("row1_pre_tick", 3'd2, 8'h07, 3'd1, 0, 0, 0, 0, 4'd11);
        step();
        chk("row1_first_shift", 3'd2, 8'h0E, 3'd1, 1, 0, 0, 0, 4'd11);

        // Asynchronous reset mid-MOVE, away from any clock edge.
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset", 3'd0, 8'h00, 3'd0, 0, 0, 0, 0, 4'd12);
        @(negedge clk);
        reset = 1'b1;
        step();
        chk("post_reset_idle", 3'd0, 8'h00, 3'd0, 0, 0, 0, 0, 4'd12);
        btn = 1'b1;
        step();
        btn = 1'b0;
        chk("post_reset_clr", 3'd1, 8'h07, 3'd0, 0, 1, 0, 0, 4'd12);
        step();
        chk("post_reset_move", 3'd2, 8'h07, 3'd0, 1, 0, 0, 0, 4'd12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
